// File: rtl/mem_fetch_ctrl_if.sv
// Bus bundle for mem_fetch_ctrl: control, memory read port and FIFO push port.
// master is the fetch engine side; slave is the surrounding system side.
interface mem_fetch_ctrl_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned LEN_W  = 16
) ();
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [LEN_W-1:0]  length;
  logic              busy;
  logic              done;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rd_data;
  logic              fifo_push;
  logic [DATA_W-1:0] fifo_data;
  logic              fifo_full;

  modport master (
    input  start, base_addr, length, mem_rd_data, fifo_full,
    output busy, done, mem_rd_en, mem_addr, fifo_push, fifo_data
  );

  modport slave (
    output start, base_addr, length, mem_rd_data, fifo_full,
    input  busy, done, mem_rd_en, mem_addr, fifo_push, fifo_data
  );
endinterface

// File: rtl/mem_fetch_ctrl.sv
// Read-side DMA engine: streams LENGTH sequential memory words into the sample FIFO
// through a 2-entry skid buffer, throttling reads so the buffer can never overflow.
module mem_fetch_ctrl #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned LEN_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  mem_fetch_ctrl_if.master bus
);

  typedef enum logic [1:0] {StIdle, StFetch, StDrain, StDone} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  remaining_q, remaining_d;
  logic              inflight_q, inflight_d;
  logic [1:0]        skid_cnt_q, skid_cnt_d;
  logic [DATA_W-1:0] skid0_q, skid0_d;
  logic [DATA_W-1:0] skid1_q, skid1_d;

  logic              rd_en;
  logic              push;
  logic [2:0]        occupancy;

  // Occupancy the skid buffer will have once the in-flight word lands and this
  // cycle's pop retires; a new read is only safe while that stays below 2.
  always_comb begin
    push      = (skid_cnt_q != 2'd0) && !bus.fifo_full;
    occupancy = {1'b0, skid_cnt_q} + {2'b00, inflight_q} - {2'b00, push};
    rd_en     = (state_q == StFetch) && (remaining_q != '0) && (occupancy < 3'd2);
  end

  // Skid buffer: skid0 is always the head; a pop shifts skid1 forward.
  always_comb begin
    skid0_d    = skid0_q;
    skid1_d    = skid1_q;
    skid_cnt_d = skid_cnt_q;
    unique case ({inflight_q, push})
      2'b01: begin
        skid0_d    = skid1_q;
        skid_cnt_d = skid_cnt_q - 2'd1;
      end
      2'b10: begin
        if (skid_cnt_q == 2'd0) begin
          skid0_d = bus.mem_rd_data;
        end else begin
          skid1_d = bus.mem_rd_data;
        end
        skid_cnt_d = skid_cnt_q + 2'd1;
      end
      2'b11: begin
        if (skid_cnt_q == 2'd1) begin
          skid0_d = bus.mem_rd_data;
        end else begin
          skid0_d = skid1_q;
          skid1_d = bus.mem_rd_data;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    inflight_d  = rd_en;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          addr_d      = bus.base_addr;
          remaining_d = bus.length;
          state_d     = (bus.length == '0) ? StDone : StFetch;
        end
      end
      StFetch: begin
        if (rd_en) begin
          addr_d      = addr_q + ADDR_W'(1);
          remaining_d = remaining_q - LEN_W'(1);
          if (remaining_q == LEN_W'(1)) begin
            state_d = StDrain;
          end
        end
      end
      // Leave on the cycle of the final pop so done follows the last push directly.
      StDrain: begin
        if (!inflight_q && (skid_cnt_d == 2'd0)) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      remaining_q <= '0;
      inflight_q  <= 1'b0;
      skid_cnt_q  <= 2'd0;
      skid0_q     <= '0;
      skid1_q     <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      inflight_q  <= inflight_d;
      skid_cnt_q  <= skid_cnt_d;
      skid0_q     <= skid0_d;
      skid1_q     <= skid1_d;
    end
  end

  assign bus.busy      = (state_q != StIdle);
  assign bus.done      = (state_q == StDone);
  assign bus.mem_rd_en = rd_en;
  assign bus.mem_addr  = addr_q;
  assign bus.fifo_push = push;
  assign bus.fifo_data = skid0_q;

  a_skid_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    (skid_cnt_q <= 2'd2) && !(inflight_q && !push && (skid_cnt_q == 2'd2)));

endmodule

// File: tb/tb_mem_fetch_ctrl.sv
// Randomized bench for mem_fetch_ctrl: a memory model answers reads one cycle later and a
// monitor compares traffic against per-transfer expectations built from the memory image.
module tb_mem_fetch_ctrl;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 10;
  localparam int unsigned LEN_W  = 16;
  localparam int unsigned MEM_N  = 1 << ADDR_W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  mem_fetch_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) bus ();

  mem_fetch_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Memory model: request seen mid-cycle, answered on the following cycle.
  logic [DATA_W-1:0] mem [MEM_N];
  logic              cap_en;
  logic [ADDR_W-1:0] cap_addr;

  always @(negedge clk) begin
    cap_en   <= bus.mem_rd_en;
    cap_addr <= bus.mem_addr;
  end

  always @(posedge clk) begin
    bus.mem_rd_data <= cap_en ? mem[cap_addr] : DATA_W'($urandom);
  end

  // Monitor state: expectations for the current transfer.
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] mon_w;
  logic [ADDR_W-1:0] exp_addr;
  int exp_len, issued, pushes, done_seen, cyc;
  int last_push_cyc, first_push_cyc, first_rd_cyc, last_rd_cyc;
  bit mon_en = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (mon_en) begin
      if (bus.mem_rd_en) begin
        check_eq("rd_addr", bus.mem_addr, exp_addr);
        check_eq("rd_overrun", issued < exp_len, 1);
        if (issued == 0) first_rd_cyc = cyc;
        last_rd_cyc = cyc;
        exp_addr++;
        issued++;
      end
      if (bus.fifo_push) begin
        check_eq("push_while_full", bus.fifo_full, 0);
        check_eq("push_extra", pushes < exp_len, 1);
        if (exp_q.size() != 0) begin
          mon_w = exp_q.pop_front();
          check_eq("push_data", bus.fifo_data, mon_w);
        end
        if (pushes == 0) first_push_cyc = cyc;
        pushes++;
        last_push_cyc = cyc;
      end
      if (bus.mem_rd_en || bus.fifo_push) begin
        check_eq("outstanding_le2", (issued - pushes) <= 2, 1);
      end
      if (bus.done) begin
        done_seen++;
        check_eq("done_push_cnt", pushes, exp_len);
        check_eq("done_busy", bus.busy, 1);
        if (exp_len != 0) check_eq("done_latency", cyc - last_push_cyc, 1);
      end
    end
  end

  // mode 0: FIFO never full; 1: fifo_full random 50%; 2: full for first 20 cycles.
  task automatic run_xfer(input logic [ADDR_W-1:0] base, input int len, input int mode,
                          input bit poke_busy);
    int k;
    logic [ADDR_W-1:0] a;
    exp_q.delete();
    for (int i = 0; i < len; i++) begin
      a = base + ADDR_W'(i);
      exp_q.push_back(mem[a]);
    end
    exp_addr  = base;
    exp_len   = len;
    issued    = 0;
    pushes    = 0;
    done_seen = 0;
    mon_en    = 1'b1;
    bus.fifo_full = (mode == 2);
    @(posedge clk); #1;
    bus.start     = 1'b1;
    bus.base_addr = base;
    bus.length    = LEN_W'(len);
    @(posedge clk); #1;
    bus.start     = 1'b0;
    bus.base_addr = ADDR_W'($urandom);
    bus.length    = LEN_W'($urandom);
    k = 0;
    while (done_seen == 0 && k < 400) begin
      bus.start = poke_busy && (k == 2);
      if (mode == 2 && k == 20) begin
        check_eq("stall_reads", issued, 2);
        check_eq("stall_rd_en", bus.mem_rd_en, 0);
        check_eq("stall_busy", bus.busy, 1);
      end
      if (mode == 1) bus.fifo_full = 1'($urandom_range(0, 1));
      else if (mode == 2) bus.fifo_full = (k < 20);
      else bus.fifo_full = 1'b0;
      @(posedge clk); #1;
      k++;
    end
    bus.start     = 1'b0;
    bus.fifo_full = 1'b0;
    check_eq("done_seen", done_seen, 1);
    if (len == 0) check_eq("len0_done_lat", k <= 2, 1);
    if (mode == 0 && len > 0) begin
      check_eq("rd_burst", last_rd_cyc - first_rd_cyc, len - 1);
      check_eq("first_push_lat", first_push_cyc - first_rd_cyc, 2);
    end
    repeat (3) @(posedge clk);
    #1;
    check_eq("single_done", done_seen, 1);
    check_eq("push_total", pushes, len);
    check_eq("reads_total", issued, len);
    check_eq("exp_left", exp_q.size(), 0);
    check_eq("idle_busy", bus.busy, 0);
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.base_addr = '0;
    bus.length    = '0;
    bus.fifo_full = 1'b0;
    for (int i = 0; i < MEM_N; i++) mem[i] = DATA_W'($urandom);
    #1;
    check_eq("rst_busy", bus.busy, 0);
    check_eq("rst_done", bus.done, 0);
    check_eq("rst_rd_en", bus.mem_rd_en, 0);
    check_eq("rst_push", bus.fifo_push, 0);
    check_eq("rst_addr", bus.mem_addr, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    run_xfer(10'h010, 8, 0, 1'b0);
    run_xfer(ADDR_W'($urandom), 16, 1, 1'b0);
    run_xfer(ADDR_W'($urandom), 4, 2, 1'b0);
    run_xfer(10'h3FE, 4, 0, 1'b0);
    run_xfer(ADDR_W'($urandom), 0, 0, 1'b0);
    run_xfer(10'h200, 12, 1, 1'b1);
    for (int t = 0; t < 8; t++) begin
      run_xfer(ADDR_W'($urandom), int'($urandom_range(1, 40)), int'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)));
    end

    // Reset in the middle of a streaming transfer.
    mon_en = 1'b0;
    @(posedge clk); #1;
    bus.start     = 1'b1;
    bus.base_addr = 10'h100;
    bus.length    = 16'd8;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check_eq("t1_active", bus.busy, 1);
    rst_n = 1'b0;
    #1;
    check_eq("t1_busy", bus.busy, 0);
    check_eq("t1_done", bus.done, 0);
    check_eq("t1_rd_en", bus.mem_rd_en, 0);
    check_eq("t1_push", bus.fifo_push, 0);
    check_eq("t1_addr", bus.mem_addr, 0);
    check_eq("t1_data", bus.fifo_data, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check_eq("t1_post_busy", bus.busy, 0);
      check_eq("t1_post_done", bus.done, 0);
      check_eq("t1_post_push", bus.fifo_push, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
